// File: rtl/demux_rr_sched.sv
// rtl/demux_rr_sched.sv - round-robin 1-to-8 serial demux with bursts and stall timeout
// Each granted channel receives up to BURST_LEN beats; a stalled sink is dropped after TIMEOUT cycles.
module demux_rr_sched #(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       i,
  output logic       in_ready,
  input  logic [7:0] ch_en,
  input  logic [7:0] ch_ready,
  output logic [7:0] y,
  output logic [7:0] y_valid,
  output logic [2:0] sel,
  output logic       burst_done,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, SCAN, XFER} state_t;

  localparam logic [7:0] LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [7:0] LAST_STALL = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [2:0] sel_q, ptr, pick;
  logic [7:0] beat_cnt, stall_cnt;
  logic       ready_c, xfer, stall, last_beat, last_stall;

  // Lowest k wins, so the search runs upward from ptr+1; k=8 wraps back to ptr itself.
  always_comb begin
    pick = ptr;
    for (int k = 8; k >= 1; k--) begin
      if (ch_en[ptr + 3'(k)]) pick = ptr + 3'(k);
    end
  end

  always_comb begin
    ready_c    = (state == XFER) & ch_en[sel_q] & ch_ready[sel_q];
    xfer       = in_valid & ready_c;
    stall      = (state == XFER) & ch_en[sel_q] & in_valid & ~ch_ready[sel_q];
    last_beat  = xfer & (beat_cnt == LAST_BEAT);
    last_stall = stall & (stall_cnt == LAST_STALL);

    in_ready   = ready_c & ~rst;
    burst_done = last_beat & ~rst;
    timeout    = last_stall & ~rst;
    sel        = rst ? 3'd0 : sel_q;
    y          = 8'd0;
    y_valid    = 8'd0;
    if (xfer && !rst) begin
      y[sel_q]       = i;
      y_valid[sel_q] = 1'b1;
    end

    state_nx = state;
    unique case (state)
      IDLE: if (|ch_en) state_nx = SCAN;
      SCAN: state_nx = (|ch_en) ? XFER : IDLE;
      XFER: begin
        if (!ch_en[sel_q] || last_beat || last_stall) state_nx = SCAN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= 3'd0;
      ptr       <= 3'd7;
      beat_cnt  <= 8'd0;
      stall_cnt <= 8'd0;
    end else begin
      state <= state_nx;
      if (state == SCAN && |ch_en) begin
        sel_q     <= pick;
        ptr       <= pick;
        beat_cnt  <= 8'd0;
        stall_cnt <= 8'd0;
      end else if (xfer) begin
        beat_cnt  <= beat_cnt + 8'd1;
        stall_cnt <= 8'd0;
      end else if (stall) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// tb/tb_demux_rr_sched.sv - randomized bench for demux_rr_sched against a cycle-level reference model
module tb_demux_rr_sched;

  localparam int BL = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst, in_valid, i, in_ready, burst_done, timeout;
  logic [7:0] ch_en, ch_ready, y, y_valid;
  logic [2:0] sel;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 choosing, 2 streaming; beats counted down.
  int m_phase, m_ptr, m_sel, m_left, m_stalls;
  bit fair_mode, want_first;
  int last_sel;

  demux_rr_sched #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .i(i), .in_ready(in_ready),
    .ch_en(ch_en), .ch_ready(ch_ready), .y(y), .y_valid(y_valid), .sel(sel),
    .burst_done(burst_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] en, input logic [7:0] rdy,
                      input logic v, input logic d);
    logic [7:0] e_y, e_yv;
    logic       e_ir, e_bd, e_to;
    int         e_sel;
    bit         xf, found;
    rst = r; ch_en = en; ch_ready = rdy; in_valid = v; i = d;
    #1;
    e_y = 0; e_yv = 0; e_ir = 0; e_bd = 0; e_to = 0; e_sel = 0;
    if (!r) begin
      e_sel = m_sel;
      e_ir  = (m_phase == 2) && en[m_sel] && rdy[m_sel];
      xf    = e_ir && v;
      if (xf) begin
        e_yv = 8'(1 << m_sel);
        e_y  = d ? e_yv : 8'h00;
      end
      e_bd = xf && (m_left == 1);
      e_to = (m_phase == 2) && en[m_sel] && v && !rdy[m_sel] && (m_stalls + 1 == TO);
    end
    check_eq("in_ready", in_ready, e_ir);
    check_eq("y", y, e_y);
    check_eq("y_valid", y_valid, e_yv);
    check_eq("sel", sel, e_sel);
    check_eq("burst_done", burst_done, e_bd);
    check_eq("timeout", timeout, e_to);

    if (fair_mode && y_valid != 0) begin
      if (last_sel >= 0 && int'(sel) != last_sel) check_eq("rr_order", sel, (last_sel + 1) % 8);
      last_sel = sel;
    end
    if (want_first && y_valid != 0) begin
      check_eq("first_grant", sel, 0);
      want_first = 0;
    end

    if (r) begin
      m_phase = 0; m_sel = 0; m_ptr = 7; last_sel = -1;
    end else begin
      case (m_phase)
        0: if (en != 0) m_phase = 1;
        1: begin
          if (en == 0) m_phase = 0;
          else begin
            found = 0;
            for (int k = 1; k <= 8; k++) begin
              if (!found && en[(m_ptr + k) % 8]) begin
                found = 1; m_sel = (m_ptr + k) % 8;
              end
            end
            m_ptr = m_sel; m_left = BL; m_stalls = 0; m_phase = 2;
          end
        end
        default: begin
          if (!en[m_sel]) m_phase = 1;
          else if (xf) begin
            m_left--; m_stalls = 0;
            if (m_left == 0) m_phase = 1;
          end else if (v && !rdy[m_sel]) begin
            m_stalls++;
            if (m_stalls == TO) m_phase = 1;
          end
        end
      endcase
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] en;
    bit hit;
    fair_mode = 0; want_first = 0; last_sel = -1;
    m_phase = 0; m_ptr = 7; m_sel = 0; m_left = 0; m_stalls = 0;
    rst = 1; ch_en = 0; ch_ready = 0; in_valid = 0; i = 0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) step(1, 8'hFF, 8'hFF, 1, 1);
    want_first = 1;

    for (int rep = 0; rep < 2; rep++) begin
      // All enabled, always ready: strict 0..7 rotation.
      fair_mode = 1; last_sel = -1;
      for (int c = 0; c < 90; c++) step(0, 8'hFF, 8'hFF, 1, 1'(c));
      fair_mode = 0;
      // Two channels only, sinks mostly ready.
      for (int c = 0; c < 80; c++)
        step(0, 8'h24, ($urandom_range(0, 3) != 0) ? 8'hFF : 8'h00, 1'($urandom), 1'($urandom));
      // Channel 3 sink dead.
      for (int c = 0; c < 150; c++) step(0, 8'hFF, 8'hF7, 1, 1'($urandom));
      // Idle source during a burst, then resume.
      for (int c = 0; c < 3; c++) step(0, 8'hFF, 8'hFF, 1, 1'($urandom));
      for (int c = 0; c < 40; c++) step(0, 8'hFF, 8'h00, 0, 1'($urandom));
      for (int c = 0; c < 20; c++) step(0, 8'hFF, 8'hFF, 1, 1'($urandom));
      // Random enables, readiness and validity, including empty masks.
      en = 8'($urandom);
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 9) == 0) en = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        step(0, en, 8'($urandom) | 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
      end
      // Reset in the middle of a channel-6 burst.
      hit = 0;
      for (int c = 0; c < 120 && !hit; c++) begin
        if (y_valid == 8'h40) hit = 1;
        else step(0, 8'hFF, 8'hFF, 1, 1'($urandom));
      end
      check_eq("reach_ch6", hit, 1);
      for (int c = 0; c < 2; c++) step(1, 8'hFF, 8'hFF, 1, 1);
      want_first = 1; fair_mode = 1; last_sel = -1;
      for (int c = 0; c < 20; c++) step(0, 8'hFF, 8'hFF, 1, 1'($urandom));
      fair_mode = 0;
      check_eq("first_seen", want_first, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
